mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port of the RV32I pipeline between two requesters: the fetch stage (I) and the memory stage (D).
- The memory stage issues lw/sw, as decoded by the control-signal unit.
- Sequences each access through a small FSM, holds the address/data stable for the memory, and produces per-requester done pulses and stall requests for the hazard logic.
- Data side has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- MAX_STARVE, 3: consecutive D grants allowed while i_req is pending before I is forced to win (1..15).
- TIMEOUT, 64: cycles allowed for mem_ready before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; held with i_addr stable until i_done
- i_addr  in  32  fetch address
- i_done  out  1  fetch access complete (1-cycle pulse)
- i_rdata  out  32  fetched instruction, valid when i_done=1
- d_req  in  1  data request; held with d_we/d_addr/d_wdata/d_be stable until d_done
- d_we  in  1  1 = store, 0 = load
- d_addr  in  32  data address
- d_wdata  in  32  store data
- d_be  in  4  byte enables
- d_done  out  1  data access complete (1-cycle pulse)
- d_rdata  out  32  load data, valid when d_done=1
- stall_f  out  1  i_req & ~i_done
- stall_m  out  1  d_req & ~d_done
- mem_req  out  1  memory access active
- mem_we  out  1  write strobe
- mem_addr  out  32  memory address
- mem_wdata  out  32  memory write data
- mem_be  out  4  memory byte enables
- mem_ready  in  1  memory completes the current access this cycle
- mem_rdata  in  32  memory read data, valid with mem_ready
- err  out  1  access aborted by timeout (1-cycle pulse, with done)

Behaviour:
- States: IDLE, IBUSY, DBUSY.
- Reset: state=IDLE; starve_cnt=0; captured addr/wdata/be/we=0; timeout counter=0.
  - Resulting outputs: mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, i_done=0, d_done=0, err=0, i_rdata=0, d_rdata=0.
  - Reset mid-transaction drops mem_req the following cycle. No done pulse is issued for the killed access.
- IDLE arbitration (registered grant):
  - d_req & ~(i_req & starve_cnt==MAX_STARVE) → DBUSY.
  - else i_req → IBUSY.
  - else stay IDLE.
- On grant, capture the winner's address, and for D also capture d_we, d_wdata and d_be; for I, we=0 and be=4'b1111.
- Starve counter:
  - D grant with i_req=1 → starve_cnt+1, saturating at MAX_STARVE.
  - Any I grant → starve_cnt=0.
  - D grant with i_req=0 → starve_cnt unchanged.
- IBUSY/DBUSY:
  - mem_req=1; mem_we/addr/wdata/be come from the captured registers.
  - mem_req=0 and mem_we=0 in IDLE.
- Completion: when mem_ready=1 in XBUSY:
  - x_done=1 combinationally in that same cycle.
  - x_rdata = mem_rdata (0 for stores), passed through combinationally; 0 whenever x_done=0.
  - Next state is IDLE.
- mem_ready in IDLE is ignored.
- Latency: request seen in IDLE at cycle N → mem_req at N+1 → done earliest at N+1 (zero-wait memory). Back-to-back accesses have one IDLE cycle between them.
- Requester deasserts req or presents a new request the cycle after done. In the done cycle the arbiter stays in XBUSY, so it never re-grants stale state.
- Simultaneous i_req & d_req with starve_cnt<MAX_STARVE → D wins.
- Only one transaction is outstanding at a time; no preemption.
- err=0 at all times unless the optional feature is enabled.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on grant and increments each XBUSY cycle with mem_ready=0.
  - When the count reaches TIMEOUT-1 with mem_ready=0, that cycle asserts x_done=1 and err=1, x_rdata=0, and the next state is IDLE.
  - mem_ready arriving in the same cycle takes precedence: normal completion, err=0.
- Undefined: no counter, err tied to 0, and XBUSY waits indefinitely for mem_ready.

Test Plan:
- Reset during DBUSY (d_req, d_addr=0x100, mem_ready held 0, assert reset 1 cycle) → next cycle mem_req=0, d_done never pulses, state IDLE, starve_cnt=0.
- Lone fetch i_req, i_addr=0x0000_0040, mem_ready=1 at first mem_req cycle, mem_rdata=0x0000_0093 → mem_req high 1 cycle, mem_we=0, mem_be=4'hF, i_done pulse with i_rdata=0x0000_0093, stall_f low afterwards.
- Store: d_req, d_we=1, d_addr=0x200, d_wdata=0xDEAD_BEEF, d_be=4'b0011, mem_ready after 2 wait cycles → mem_we=1, mem_addr=0x200, mem_wdata=0xDEAD_BEEF, mem_be=0011 held 3 cycles, d_done on the 3rd cycle, d_rdata=0.
- Simultaneous i_req & d_req, both re-requesting continuously, MAX_STARVE=3, zero-wait memory → grant order D,D,D,I,D,D,D,I; stall_f high until its i_done.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=8, d_req load with mem_ready stuck 0 → d_done=1 and err=1 on the 8th DBUSY cycle, d_rdata=0, mem_req=0 the next cycle. Without the macro, mem_req stays high and err stays 0.
- mem_ready pulsed in IDLE with no requests → no done pulse, state IDLE, all mem_* outputs remain 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared RV32I memory port between fetch (I) and memory-stage (D) requesters.
// Optional access timeout is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned MAX_STARVE = 3,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        stall_f,
  output logic        stall_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_MAX = 4'(MAX_STARVE);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;

  logic busy;
  logic complete;
  logic abort;
  logic finish;
  logic force_i;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    busy     = (state_q != IDLE);
    complete = busy && mem_ready;
`ifdef MEM_ARB_TIMEOUT_EN
    // A late mem_ready on the final cycle still wins over the abort.
    abort    = busy && !mem_ready && (to_cnt_q == TO_LAST);
`else
    abort    = 1'b0;
`endif
    finish   = complete || abort;
    force_i  = i_req && (starve_q == STARVE_MAX);

    state_d  = state_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
`ifdef MEM_ARB_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_d = 16'd0;
`endif
        if (d_req && !force_i) begin
          state_d = DBUSY;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          be_d    = d_be;
          we_d    = d_we;
          // force_i is clear here, so the count is below MAX_STARVE and cannot overflow.
          if (i_req) starve_d = starve_q + 4'd1;
        end else if (i_req) begin
          state_d  = IBUSY;
          addr_d   = i_addr;
          wdata_d  = 32'd0;
          be_d     = 4'hF;
          we_d     = 1'b0;
          starve_d = 4'd0;
        end
      end
      default: begin
        if (finish) state_d = IDLE;
`ifdef MEM_ARB_TIMEOUT_EN
        if (!mem_ready) to_cnt_d = to_cnt_q + 16'd1;
`endif
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      we_q     <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt_q <= 16'd0;
`endif
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
`ifdef MEM_ARB_TIMEOUT_EN
      to_cnt_q <= to_cnt_d;
`endif
    end
  end

  // Valid/ready contract: a requester holds req and its fields stable until its done
  // pulse; done coincides with mem_ready (or abort) while the arbiter is still busy.
  assign mem_req   = busy;
  assign mem_we    = busy && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign i_done  = (state_q == IBUSY) && finish;
  assign d_done  = (state_q == DBUSY) && finish;
  assign i_rdata = ((state_q == IBUSY) && complete) ? mem_rdata : 32'd0;
  assign d_rdata = ((state_q == DBUSY) && complete && !we_q) ? mem_rdata : 32'd0;
  assign err     = abort;

  assign stall_f   = i_req && !i_done;
  assign stall_m   = d_req && !d_done;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int MAX_STARVE = 3;
  localparam int TIMEOUT    = 8;

  logic        clk, reset;
  logic        i_req, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        stall_f, stall_m;
  logic        mem_req, mem_we, mem_ready, err;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic [1:0]  dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one outstanding access, fetch forced after MAX_STARVE data wins.
  bit          m_busy, m_own_d, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  int          m_wait, m_streak;
  logic [31:0] exp_q[$];
  bit          seen_idone, seen_ddone;

  mem_port_arbiter #(.MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_done(d_done), .d_rdata(d_rdata),
    .stall_f(stall_f), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .err(err), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own_d = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_be = 0;
    m_wait = 0; m_streak = 0; seen_idone = 0; seen_ddone = 0;
    exp_q.delete();
  endtask

  task automatic model_check();
    bit fin, abt, e_idone, e_ddone;
    logic [31:0] e_ir, e_dr;
    fin = 0; abt = 0; e_idone = 0; e_ddone = 0; e_ir = 0; e_dr = 0;
    if (m_busy) begin
      fin = mem_ready;
`ifdef MEM_ARB_TIMEOUT_EN
      abt = !mem_ready && (m_wait == TIMEOUT - 1);
`endif
      if (fin || abt) begin
        if (m_own_d) begin
          e_ddone = 1;
          e_dr = (fin && !m_we) ? mem_rdata : 32'd0;
        end else begin
          e_idone = 1;
          e_ir = fin ? mem_rdata : 32'd0;
        end
      end
    end
    check("mem_req", mem_req, m_busy);
    check("mem_we", mem_we, m_busy && m_we);
    if (m_busy) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_be", mem_be, m_be);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("i_done", i_done, e_idone);
    check("d_done", d_done, e_ddone);
    check("i_rdata", i_rdata, e_ir);
    check("d_rdata", d_rdata, e_dr);
    check("err", err, abt);
    check("stall_f", stall_f, i_req && !e_idone);
    check("stall_m", stall_m, d_req && !e_ddone);
    if (e_idone || e_ddone) begin
      if (exp_q.size() == 0) check("sb_empty", 1, 0);
      else check("sb_addr", mem_addr, exp_q.pop_front());
    end
    // Advance the model by one cycle.
    if (m_busy) begin
      if (fin || abt) m_busy = 0;
      else m_wait++;
    end else if (d_req && !(i_req && m_streak >= MAX_STARVE)) begin
      m_busy = 1; m_own_d = 1; m_wait = 0;
      m_addr = d_addr; m_wdata = d_wdata; m_be = d_be; m_we = d_we;
      if (i_req && m_streak < MAX_STARVE) m_streak++;
      exp_q.push_back(d_addr);
    end else if (i_req) begin
      m_busy = 1; m_own_d = 0; m_wait = 0;
      m_addr = i_addr; m_be = 4'hF; m_we = 0;
      m_streak = 0;
      exp_q.push_back(i_addr);
    end
  endtask

  task automatic sample_edge();
    @(negedge clk);
    model_check();
    seen_idone = i_done;
    seen_ddone = d_done;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1; i_req = 0; d_req = 0; mem_ready = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    mem_ready = 1;
    while ((i_req || d_req) && guard < 40) begin
      sample_edge();
      advance();
      if (seen_idone) i_req = 0;
      if (seen_ddone) d_req = 0;
      guard++;
    end
    check("drain_idle", {30'd0, i_req, d_req}, 32'd0);
    sample_edge();
    advance();
    mem_ready = 0;
  endtask

  initial begin
    logic [7:0] order;
    int n_g;
    logic prev_req;

    reset = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0;
    d_wdata = 0; d_be = 0; mem_ready = 0; mem_rdata = 32'hA5A5_5A5A;
    apply_reset();

    // Reset state, with mem_ready pulsed while idle
    mem_ready = 1;
    sample_edge();
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_state", dbg_state, 0);
    advance();
    mem_ready = 0;

    // Lone fetch, zero-wait
    i_req = 1; i_addr = 32'h0000_0040;
    sample_edge();
    advance();
    mem_ready = 1; mem_rdata = 32'h0000_0093;
    sample_edge();
    check("fetch_req", mem_req, 1);
    check("fetch_be", mem_be, 4'hF);
    check("fetch_addr", mem_addr, 32'h40);
    check("fetch_done", i_done, 1);
    check("fetch_rdata", i_rdata, 32'h93);
    advance();
    i_req = 0; mem_ready = 0;
    sample_edge();
    check("fetch_after_req", mem_req, 0);
    check("fetch_after_stall", stall_f, 0);
    advance();

    // Store with two wait states
    d_req = 1; d_we = 1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
    mem_rdata = 32'h1234_5678;
    sample_edge();
    advance();
    for (int k = 1; k <= 3; k++) begin
      mem_ready = (k == 3);
      sample_edge();
      check("store_we", mem_we, 1);
      check("store_addr", mem_addr, 32'h200);
      check("store_wdata", mem_wdata, 32'hDEAD_BEEF);
      check("store_be", mem_be, 4'b0011);
      check("store_done", d_done, (k == 3));
      check("store_rdata", d_rdata, 0);
      advance();
    end
    d_req = 0; d_we = 0; mem_ready = 0;
    sample_edge();
    advance();

    // Reset in the middle of a data access
    d_req = 1; d_addr = 32'h100; d_be = 4'hF;
    sample_edge();
    advance();
    sample_edge();
    check("rstmid_busy", mem_req, 1);
    advance();
    reset = 1;
    sample_edge();
    advance();
    reset = 0; d_req = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      sample_edge();
      check("rstmid_req", mem_req, 0);
      check("rstmid_ddone", d_done, 0);
      check("rstmid_state", dbg_state, 0);
      advance();
    end

    // Contention: fetch must win every (MAX_STARVE+1)-th grant
    apply_reset();
    i_req = 1; d_req = 1; d_we = 0; d_be = 4'hF;
    i_addr = 32'h1000; d_addr = 32'h2000; mem_ready = 1;
    n_g = 0; prev_req = 0; order = 0;
    for (int c = 0; c < 60 && n_g < 8; c++) begin
      sample_edge();
      if (mem_req && !prev_req) begin
        order[n_g[2:0]] = (mem_addr[13:12] == 2'd2);
        n_g++;
      end
      prev_req = mem_req;
      advance();
      if (seen_idone) i_addr += 4;
      if (seen_ddone) d_addr += 4;
    end
    check("starve_ngrants", n_g, 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("starve_order%0d", k), order[k], ((k % (MAX_STARVE + 1)) != MAX_STARVE));
    drain();

    // Memory that never answers
    apply_reset();
    d_req = 1; d_we = 0; d_addr = 32'h300; d_be = 4'hF; mem_rdata = 32'hCAFE_F00D;
    sample_edge();
    advance();
`ifdef MEM_ARB_TIMEOUT_EN
    for (int k = 1; k <= TIMEOUT; k++) begin
      sample_edge();
      check("to_done", d_done, (k == TIMEOUT));
      check("to_err", err, (k == TIMEOUT));
      check("to_rdata", d_rdata, 0);
      advance();
    end
    d_req = 0;
    sample_edge();
    check("to_after_req", mem_req, 0);
    advance();
`else
    for (int k = 1; k <= 20; k++) begin
      sample_edge();
      check("hang_req", mem_req, 1);
      check("hang_err", err, 0);
      advance();
    end
    drain();
`endif

    // Random traffic
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!i_req || seen_idone) begin
        i_req  = ($urandom_range(0, 3) != 0);
        i_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!d_req || seen_ddone) begin
        d_req   = ($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_be    = 4'($urandom_range(0, 15));
      end
      mem_ready = ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      sample_edge();
      advance();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
